mux_arb_knton: RTL and testbench

Registered, parametrised K:1 stream multiplexer with per-input valid, downstream ready backpressure, and two selection modes: fixed select or round-robin arbitration. Generalises the combinational 2:1/4:1 enable-muxes to any channel count and width, and adds a one-entry output register and a handshake. It sits where several producers (forwarding paths, memory-return sources, peripheral reads) share one consumer port and the consumer can stall.

---
 rtl/mux_arb_knton.sv | 85 ++++++++
 tb/tb_mux_arb_knton.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_knton.sv
// Registered K:1 stream mux with fixed-select or round-robin arbitration.
// One-entry output register, valid/ready handshake toward the consumer.
module mux_arb_knton #(
  parameter int N = 32,
  parameter int K = 4,
  localparam int SW = $clog2(K)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [K*N-1:0]  I,
  input  logic [K-1:0]    V,
  input  logic [SW-1:0]   S,
  input  logic            mode,
  input  logic            enable,
  input  logic            ready,
  output logic [K-1:0]    grant,
  output logic [N-1:0]    O,
  output logic            valid,
  output logic [SW-1:0]   sel_o
);

  logic [SW-1:0] ptr;
  logic          rr_hit;
  logic [SW-1:0] rr_idx;
  logic          fx_hit;
  logic          hit;
  logic [SW-1:0] win;
  logic          accept;
  logic [N-1:0]  win_data;

  // Round-robin search from ptr+1 upward; scanning backwards leaves the
  // closest requester in rr_idx.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    for (int j = K; j >= 1; j--) begin
      int c;
      c = (int'(ptr) + j) % K;
      if (V[c]) begin
        rr_hit = 1'b1;
        rr_idx = SW'(c);
      end
    end
  end

  // Fixed select; out-of-range S selects nothing when K is not a power of 2.
  always_comb begin
    fx_hit = 1'b0;
    if (int'(S) < K) fx_hit = V[S];
  end

  // Winner, accept decision and one-hot grant.
  always_comb begin
    hit    = mode ? rr_hit : fx_hit;
    win    = mode ? rr_idx : S;
    accept = rst && enable && (!valid || ready) && hit;
    grant  = accept ? (K'(1) << win) : '0;
  end

  // Data mux for the winning channel.
  always_comb begin
    win_data = '0;
    for (int i = 0; i < K; i++) begin
      if (win == SW'(i)) win_data = I[i*N +: N];
    end
  end

  // Output register, drain on ready, round-robin pointer update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= 1'b0;
      O     <= '0;
      sel_o <= '0;
      ptr   <= SW'(K - 1);
    end else if (accept) begin
      valid <= 1'b1;
      O     <= win_data;
      sel_o <= win;
      if (mode) ptr <= win;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_knton.sv
// Self-checking bench for mux_arb_knton (N=8, K=4).
// Directed steps followed by random traffic against a queue-based model.
module tb_mux_arb_knton;
  localparam int N = 8;
  localparam int K = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [K*N-1:0] I;
  logic [K-1:0]  V;
  logic [SW-1:0] S;
  logic          mode;
  logic          enable;
  logic          ready;
  logic [K-1:0]  grant;
  logic [N-1:0]  O;
  logic          valid;
  logic [SW-1:0] sel_o;

  int n_cmp = 0;
  int n_bad = 0;

  int slot[$];
  logic [N-1:0] m_o;
  int m_sel;
  int rr_last;
  int m_win;
  bit m_acc;
  logic [K-1:0] m_grant;
  logic [K-1:0] g_obs;

  mux_arb_knton #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .I(I), .V(V), .S(S), .mode(mode),
    .enable(enable), .ready(ready), .grant(grant), .O(O),
    .valid(valid), .sel_o(sel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] ch(input int i);
    logic [K*N-1:0] t;
    t = I;
    return t[i*N +: N];
  endfunction

  task automatic model_pre();
    m_win = -1;
    if (!mode) begin
      if (int'(S) < K && V[S]) m_win = int'(S);
    end else begin
      for (int k = 1; k <= K; k++) begin
        int c;
        c = (rr_last + k) % K;
        if (m_win < 0 && V[c]) m_win = c;
      end
    end
    m_acc = rst && enable && (slot.size() == 0 || ready) && m_win >= 0;
    m_grant = m_acc ? K'(1 << m_win) : '0;
  endtask

  task automatic model_post(input logic [N-1:0] d);
    if (!rst) begin
      slot.delete();
      m_o = '0;
      m_sel = 0;
      rr_last = K - 1;
    end else begin
      if (ready && slot.size() != 0) void'(slot.pop_front());
      if (m_acc) begin
        slot.push_back(m_win);
        m_o = d;
        m_sel = m_win;
        if (mode) rr_last = m_win;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] d;
    #1;
    model_pre();
    d = (m_win >= 0) ? ch(m_win) : '0;
    g_obs = grant;
    chk("grant", 32'(grant), 32'(m_grant));
    @(posedge clk);
    #1;
    model_post(d);
    chk("valid", 32'(valid), 32'(slot.size() != 0));
    chk("O", 32'(O), 32'(m_o));
    chk("sel_o", 32'(sel_o), 32'(m_sel));
  endtask

  task automatic set_ch(input int i, input logic [N-1:0] d);
    I[i*N +: N] = d;
  endtask

  initial begin
    rr_last = K - 1;
    m_o = '0;
    m_sel = 0;
    rst = 1'b0; I = $urandom; V = 4'hF; S = '0;
    mode = 1'b1; enable = 1'b1; ready = 1'b1;

    // reset held two cycles
    step();
    step();
    chk("rst_grant", 32'(g_obs), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_O", 32'(O), 0);
    chk("rst_sel", 32'(sel_o), 0);
    rst = 1'b1;
    step();
    chk("rr_first", 32'(g_obs), 32'h1);

    // fixed select
    mode = 1'b0; S = 2'd2; V = 4'b0100; set_ch(2, 8'hA5);
    step();
    chk("fx_grant", 32'(g_obs), 32'h4);
    chk("fx_O", 32'(O), 32'hA5);
    chk("fx_sel", 32'(sel_o), 2);
    S = 2'd1;
    step();
    chk("fx_none", 32'(g_obs), 0);
    chk("fx_drop", 32'(valid), 0);

    // round-robin fairness from a fresh pointer
    rst = 1'b0; step(); rst = 1'b1;
    mode = 1'b1; V = 4'hF;
    for (int k = 0; k < 8; k++) begin
      I = $urandom;
      step();
      chk("rr_seq", 32'(g_obs), 32'(1 << (k % K)));
      chk("rr_sel", 32'(sel_o), 32'(k % K));
    end

    // backpressure with a held word
    mode = 1'b0; S = 2'd0; V = 4'b0001; set_ch(0, 8'h11);
    step();
    ready = 1'b0; mode = 1'b1; V = 4'hF; I = $urandom;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_O", 32'(O), 32'h11);
      chk("bp_valid", 32'(valid), 1);
      chk("bp_grant", 32'(g_obs), 0);
    end
    ready = 1'b1;
    step();
    chk("bp_resume", 32'(g_obs != 0), 1);
    chk("bp_nobubble", 32'(valid), 1);

    // enable low drains the held word
    enable = 1'b0;
    step();
    chk("en_grant", 32'(g_obs), 0);
    chk("en_drain", 32'(valid), 0);
    enable = 1'b1;
    step();

    // skip and wrap, then reset mid-stall
    rst = 1'b0; step(); rst = 1'b1;
    V = 4'hF; step(); step();
    V = 4'b0001; step();
    chk("rr_wrap", 32'(g_obs), 32'h1);
    V = 4'b1001; step();
    chk("rr_skip", 32'(g_obs), 32'h8);
    ready = 1'b0; step();
    rst = 1'b0; step();
    chk("rst_stall", 32'(valid), 0);
    rst = 1'b1; ready = 1'b1;

    // random traffic
    for (int k = 0; k < 400; k++) begin
      I = $urandom;
      V = 4'($urandom);
      S = 2'($urandom);
      mode = 1'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 49) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
